// File: rtl/dbg_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbg_uart_pkg
// Purpose  : Shared definitions for the debug-word receiver: ASCII constants
//            of the "0x" + 8 hex + CR LF record, byte/parser state types and
//            the hex-digit decoder.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package dbg_uart_pkg;

  localparam logic [7:0] c_ZERO = 8'h30;  // '0'
  localparam logic [7:0] c_LC_X = 8'h78;  // 'x'
  localparam logic [7:0] c_UC_X = 8'h58;  // 'X'
  localparam logic [7:0] c_CR   = 8'h0D;  // '\r'
  localparam logic [7:0] c_LF   = 8'h0A;  // '\n'

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_state_t;

  typedef enum logic [2:0] {P_ZERO, P_X, P_HEX, P_CR, P_LF} parse_state_t;

  // Returns {valid, nibble}. Letters a-f/A-F share the low nibble 1..6, so
  // adding 9 maps them onto 10..15.
  function automatic logic [4:0] hex_decode(input logic [7:0] i_ch);
    logic [4:0] w_res;
    w_res = 5'b0_0000;
    if (i_ch >= 8'h30 && i_ch <= 8'h39) begin
      w_res = {1'b1, i_ch[3:0]};
    end else if ((i_ch >= 8'h41 && i_ch <= 8'h46) ||
                 (i_ch >= 8'h61 && i_ch <= 8'h66)) begin
      w_res = {1'b1, i_ch[3:0] + 4'd9};
    end
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_rx
// Purpose  : 8N1 serial byte receiver with 2-flop input synchroniser.
// Ports    : i_clk        system clock
//            i_reset_n    asynchronous active-low reset
//            i_rx         serial input, idle high
//            o_byte_stb   1-cycle pulse at mid-stop-bit sample of a good byte
//            o_byte       last received byte (valid with o_byte_stb)
//            o_frame_err  1-cycle pulse when the stop bit samples low
// Revision : 1.0  initial release
// ============================================================================
module uart_byte_rx
  import dbg_uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 217
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rx,
  output logic       o_byte_stb,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam int            CW      = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] c_FULL  = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] c_HALF  = CW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] c_ONE   = CW'(1);

  logic [1:0]    r_sync;
  logic          w_rx;
  logic          w_tick;
  byte_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]    r_idx,   w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  // Set after a framing error so a line held low (break) is not taken as
  // a fresh start bit; cleared once the line is seen high again.
  logic          r_brk,   w_brk_nxt;

  assign w_rx   = r_sync[1];
  assign w_tick = (r_cnt == '0);
  assign o_byte = r_shift;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_brk   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_brk   <= w_brk_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_brk_nxt   = r_brk;
    o_byte_stb  = 1'b0;
    o_frame_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_brk) begin
          if (w_rx) w_brk_nxt = 1'b0;
        end else if (!w_rx) begin
          // Half a bit period lands the next samples mid-bit.
          w_cnt_nxt   = c_HALF;
          w_state_nxt = START;
        end
      end
      START: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - c_ONE;
        end else if (w_rx) begin
          w_state_nxt = IDLE;  // glitch, not a real start bit
        end else begin
          w_cnt_nxt   = c_FULL;
          w_idx_nxt   = 3'd0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - c_ONE;
        end else begin
          w_shift_nxt = {w_rx, r_shift[7:1]};  // LSB first
          w_cnt_nxt   = c_FULL;
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - c_ONE;
        end else begin
          w_state_nxt = IDLE;
          if (w_rx) begin
            o_byte_stb = 1'b1;
          end else begin
            o_frame_err = 1'b1;
            w_brk_nxt   = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dbg_word_rx.sv
`default_nettype none
// ============================================================================
// Module   : dbg_word_rx
// Purpose  : Receives the debug UART stream and parses "0x" + 8 hex digits
//            + CR LF records back into a 32-bit word.
// Ports    : i_clk      system clock
//            i_reset_n  asynchronous active-low reset
//            i_uart_rx  serial input, idle high, asynchronous
//            o_stb      1-cycle pulse, valid record received (o_data updated)
//            o_data     last successfully parsed word
//            o_err      1-cycle pulse, framing error or malformed record
// Revision : 1.0  initial release
// ============================================================================
module dbg_word_rx
  import dbg_uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 217
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_uart_rx,
  output logic        o_stb,
  output logic [31:0] o_data,
  output logic        o_err
);

  logic         w_byte_stb;
  logic         w_frame_err;
  logic [7:0]   w_byte;
  logic [4:0]   w_hex;
  logic         w_bad;
  logic         w_stb_nxt;
  logic         w_err_nxt;

  parse_state_t r_pstate, w_pstate_nxt;
  logic [31:0]  r_shift,  w_shift_nxt;
  logic [3:0]   r_digits, w_digits_nxt;

  uart_byte_rx #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_byte_rx (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_rx        (i_uart_rx),
    .o_byte_stb  (w_byte_stb),
    .o_byte      (w_byte),
    .o_frame_err (w_frame_err)
  );

  assign w_hex = hex_decode(w_byte);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pstate <= P_ZERO;
      r_shift  <= '0;
      r_digits <= '0;
      o_stb    <= 1'b0;
      o_err    <= 1'b0;
      o_data   <= '0;
    end else begin
      r_pstate <= w_pstate_nxt;
      r_shift  <= w_shift_nxt;
      r_digits <= w_digits_nxt;
      o_stb    <= w_stb_nxt;
      o_err    <= w_err_nxt;
      if (w_stb_nxt) o_data <= r_shift;
    end
  end

  always_comb begin
    w_pstate_nxt = r_pstate;
    w_shift_nxt  = r_shift;
    w_digits_nxt = r_digits;
    w_stb_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    w_bad        = 1'b0;
    if (w_frame_err) begin
      w_err_nxt    = 1'b1;
      w_pstate_nxt = P_ZERO;
    end else if (w_byte_stb) begin
      case (r_pstate)
        P_ZERO: begin
          // Anything before a '0' is inter-record noise and silently dropped.
          if (w_byte == c_ZERO) w_pstate_nxt = P_X;
        end
        P_X: begin
          if (w_byte == c_LC_X || w_byte == c_UC_X) begin
            w_pstate_nxt = P_HEX;
            w_shift_nxt  = '0;
            w_digits_nxt = 4'd0;
          end else begin
            w_bad = 1'b1;
          end
        end
        P_HEX: begin
          if (w_hex[4]) begin
            w_shift_nxt  = {r_shift[27:0], w_hex[3:0]};
            w_digits_nxt = r_digits + 4'd1;
            if (r_digits == 4'd7) w_pstate_nxt = P_CR;
          end else begin
            w_bad = 1'b1;
          end
        end
        P_CR: begin
          if (w_byte == c_CR) w_pstate_nxt = P_LF;
          else                w_bad = 1'b1;
        end
        P_LF: begin
          if (w_byte == c_LF) begin
            w_stb_nxt    = 1'b1;
            w_pstate_nxt = P_ZERO;
          end else begin
            w_bad = 1'b1;
          end
        end
        default: w_pstate_nxt = P_ZERO;
      endcase
      // A stray '0' may itself open the next record, so resync on it.
      if (w_bad) begin
        w_err_nxt    = 1'b1;
        w_pstate_nxt = (w_byte == c_ZERO) ? P_X : P_ZERO;
      end
    end
  end

endmodule
`default_nettype wire
